ctrl_decode_seq: RTL and testbench
==================================

// Module: ctrl_decode_seq
// PURPOSE
//  Sequential, parametrised control decoder sitting between instruction fetch and the datapath.
//  Accepts instruction words over a valid/ready handshake and emits one registered control bundle per decoded op.
//  Handles the two-word load-immediate (li) sequence and stalls fetch for configurable load latency.
// PARAMETERS
//  IW        7    instruction word width; opcode is instr[IW-1:IW-OPW]
//  OPW       3    opcode width
//  ALUW      3    ALU op width
//  RDW       2    destination-register field width; li dest is instr[RDW-1:0]
//  LOAD_LAT  2    stall cycles after an lbu is accepted (0 = no stall)
//  CNT_W     16   perf counter width (used only with CTRL_PERF_CNT_EN)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  reset_n      in   1        synchronous active-low reset
//  instr_valid  in   1        instr holds a word this cycle
//  instr        in   IW       instruction / immediate word
//  instr_ready  out  1        decoder can accept; transfer = instr_valid & instr_ready
//  dec_valid    out  1        control bundle valid (one-cycle pulse per decoded op)
//  branch       out  1        beq
//  mem_to_reg   out  1        route memory to reg-file write data
//  mem_write    out  1        store
//  alu_src      out  1        1: immediate operand, 0: reg-file operand
//  reg_write    out  1        reg-file write enable
//  alu_op       out  ALUW     ALU operation
//  reg_dst      out  RDW      destination register for li write
//  li_pending   out  1        1 while in S_LI (prefix taken, immediate not yet taken)
//  dec_count    out  CNT_W    decoded-op counter (only with CTRL_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=S_NORM, stall counter=0; all outputs 0 except instr_ready=1 and alu_op='1 (111).
//  - Latency: bundle registered; appears 1 cycle after the accepting edge, held 1 cycle with dec_valid=1.
//  - dec_valid=0 -> control strobes (branch, mem_write, reg_write, mem_to_reg) are 0; alu_op=111, alu_src=0.
//  - States: S_NORM, S_LI, S_STALL.
//  - S_NORM, transfer, instr[IW-1:RDW]==0 (li prefix): latch reg_dst=instr[RDW-1:0], go S_LI, no dec_valid.
//  - S_NORM, transfer, otherwise decode on opcode; alu_op=opcode zero-extended/truncated to ALUW.
//    000 add: reg_write. 001 beq: branch. 010 sb: mem_write. 011 lbu: mem_to_reg, reg_write.
//    100 xor, 101 or, 110 and, 111 srl: reg_write. alu_src=0 for all.
//  - lbu with LOAD_LAT>0: go S_STALL, counter=LOAD_LAT, instr_ready=0.
//    Decrement each cycle; return to S_NORM the cycle after count reaches 1. LOAD_LAT=0: stay S_NORM.
//  - S_LI, transfer: word is immediate (not decoded).
//    Emit dec_valid, reg_write=1, alu_src=1, alu_op=000, reg_dst=latched; go S_NORM.
//  - S_LI without transfer: hold state and latched reg_dst indefinitely.
//  - instr_ready = (state != S_STALL); combinational from state only, never from instr_valid.
//  - reg_dst retains last latched value outside li; only meaningful with li bundle.
//  - Reset mid-li or mid-stall: abandon sequence, return to S_NORM; a following immediate word decodes as an instruction.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined:
//    dec_count port exists; increments by 1 each cycle dec_valid=1 (li pair counts once).
//    Wraps from 2^CNT_W-1 to 0; reset to 0.
//  CTRL_PERF_CNT_EN undefined: dec_count port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: hold reset_n=0 two cycles -> instr_ready=1, dec_valid=0, alu_op=111, li_pending=0.
//  2 instr=7'b1000101 valid one cycle -> next cycle dec_valid=1, alu_op=100, reg_write=1, all others 0.
//  3 li: instr=7'b0000010 then 7'b0101010 -> li_pending=1 after first, no dec_valid.
//    After second: dec_valid=1, reg_write=1, alu_src=1, alu_op=000, reg_dst=10.
//  4 lbu 7'b0110100, LOAD_LAT=2 -> bundle mem_to_reg=1, reg_write=1.
//    instr_ready=0 exactly 2 cycles; word offered during stall not consumed.
//  5 li prefix, valid low 5 cycles, then reset_n=0 -> S_NORM.
//    Next word 7'b0100000 decodes as sb (mem_write=1), not as immediate.
//  6 CTRL_PERF_CNT_EN, CNT_W=4: 17 decoded ops incl. one li pair -> dec_count=1 (wrapped).

Source files
------------

// File: rtl/ctrl_decode_seq.sv
// ctrl_decode_seq
//   Sequential control decoder between instruction fetch and the datapath.
//   Takes instruction words over a valid/ready handshake and emits one
//   registered control bundle per decoded op. A word whose upper bits
//   instr[IW-1:RDW] are all zero is a load-immediate prefix. The word after
//   it is the immediate, and the bundle for the pair is emitted when that
//   word arrives. An accepted lbu holds fetch off for LOAD_LAT cycles.
//
//   Optional feature macro: CTRL_PERF_CNT_EN. When it is defined, the
//   dec_count port and the decoded-op counter are present.
//
// Ports
//   clk, reset_n          clock and synchronous active-low reset
//   instr_valid, instr    incoming instruction / immediate word
//   instr_ready           decoder can accept; low only while stalling on lbu
//   dec_valid             one-cycle pulse with each registered control bundle
//   branch, mem_to_reg, mem_write, alu_src, reg_write, alu_op, reg_dst
//                         control bundle
//   li_pending            li prefix taken, immediate not yet taken
//   dec_count             decoded-op counter (CTRL_PERF_CNT_EN only)
module ctrl_decode_seq #(
   parameter int unsigned IW       = 7,
   parameter int unsigned OPW      = 3,
   parameter int unsigned ALUW     = 3,
   parameter int unsigned RDW      = 2,
   parameter int unsigned LOAD_LAT = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            instr_valid,
   input  logic [IW-1:0]   instr,
   output logic            instr_ready,
   output logic            dec_valid,
   output logic            branch,
   output logic            mem_to_reg,
   output logic            mem_write,
   output logic            alu_src,
   output logic            reg_write,
   output logic [ALUW-1:0] alu_op,
   output logic [RDW-1:0]  reg_dst,
   output logic            li_pending
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] dec_count
`endif
);

   localparam int unsigned SW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

   typedef enum logic [1:0] {S_NORM, S_LI, S_STALL} state_t;

   state_t          state, state_d;
   logic [SW-1:0]   stall_cnt, stall_cnt_d;
   logic [OPW-1:0]  opc;
   logic            take;
   logic            is_prefix;

   logic            nx_dv, nx_br, nx_m2r, nx_mw, nx_src, nx_rw;
   logic [ALUW-1:0] nx_alu;
   logic [RDW-1:0]  nx_rd;

   assign opc         = instr[IW-1:IW-OPW];
   assign is_prefix   = (instr[IW-1:RDW] == '0);
   // Ready depends only on state. This keeps a combinational path from
   // instr_valid out of the handshake.
   assign instr_ready = (state != S_STALL);
   assign take        = instr_valid & instr_ready;
   assign li_pending  = (state == S_LI);

   always_comb begin
      state_d     = state;
      stall_cnt_d = stall_cnt;
      nx_dv       = 1'b0;
      nx_br       = 1'b0;
      nx_m2r      = 1'b0;
      nx_mw       = 1'b0;
      nx_src      = 1'b0;
      nx_rw       = 1'b0;
      nx_alu      = '1;
      nx_rd       = reg_dst;
      case (state)
         S_NORM: begin
            if (take) begin
               if (is_prefix) begin
                  nx_rd   = instr[RDW-1:0];
                  state_d = S_LI;
               end else begin
                  nx_dv  = 1'b1;
                  nx_alu = ALUW'(opc);
                  if (opc == OPW'(1)) begin
                     nx_br = 1'b1;
                  end else if (opc == OPW'(2)) begin
                     nx_mw = 1'b1;
                  end else if (opc == OPW'(3)) begin
                     nx_m2r = 1'b1;
                     nx_rw  = 1'b1;
                     if (LOAD_LAT > 0) begin
                        state_d     = S_STALL;
                        stall_cnt_d = SW'(LOAD_LAT);
                     end
                  end else begin
                     nx_rw = 1'b1;
                  end
               end
            end
         end
         S_LI: begin
            if (take) begin
               nx_dv   = 1'b1;
               nx_rw   = 1'b1;
               nx_src  = 1'b1;
               nx_alu  = '0;
               state_d = S_NORM;
            end
         end
         S_STALL: begin
            // Leave on the edge where the count is 1, so ready stays low for
            // exactly LOAD_LAT cycles.
            if (stall_cnt <= SW'(1)) begin
               state_d     = S_NORM;
               stall_cnt_d = '0;
            end else begin
               stall_cnt_d = stall_cnt - SW'(1);
            end
         end
         default: state_d = S_NORM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_NORM;
         stall_cnt  <= '0;
         dec_valid  <= 1'b0;
         branch     <= 1'b0;
         mem_to_reg <= 1'b0;
         mem_write  <= 1'b0;
         alu_src    <= 1'b0;
         reg_write  <= 1'b0;
         alu_op     <= '1;
         reg_dst    <= '0;
      end else begin
         state      <= state_d;
         stall_cnt  <= stall_cnt_d;
         dec_valid  <= nx_dv;
         branch     <= nx_br;
         mem_to_reg <= nx_m2r;
         mem_write  <= nx_mw;
         alu_src    <= nx_src;
         reg_write  <= nx_rw;
         alu_op     <= nx_alu;
         reg_dst    <= nx_rd;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dec_count <= '0;
      end else if (dec_valid) begin
         dec_count <= dec_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ctrl_decode_seq.sv
// tb_ctrl_decode_seq
//   Self-checking bench for ctrl_decode_seq (IW=7, OPW=3, ALUW=3, RDW=2,
//   LOAD_LAT=2; CNT_W=4 when CTRL_PERF_CNT_EN is defined). Expected bundles
//   are pushed to a queue when stimulus is driven and popped when the DUT
//   presents its registered bundle.
module tb_ctrl_decode_seq;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       instr_valid;
   logic [6:0] instr;
   logic       instr_ready, dec_valid, branch, mem_to_reg, mem_write;
   logic       alu_src, reg_write, li_pending;
   logic [2:0] alu_op;
   logic [1:0] reg_dst;
`ifdef CTRL_PERF_CNT_EN
   logic [3:0] dec_count;
`endif

   int unsigned checks = 0;
   int unsigned passed = 0;

   // Bundle layout: {dec_valid, branch, mem_to_reg, mem_write, alu_src,
   // reg_write, alu_op[2:0], reg_dst[1:0]}
   logic [10:0] sb_q[$];
   logic [10:0] obs;
   logic [10:0] exp_b;
   logic [1:0]  m_rd;

   assign obs = {dec_valid, branch, mem_to_reg, mem_write, alu_src,
                 reg_write, alu_op, reg_dst};

   always #5 clk = ~clk;

   ctrl_decode_seq #(
      .IW(7), .OPW(3), .ALUW(3), .RDW(2), .LOAD_LAT(2), .CNT_W(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .dec_valid(dec_valid), .branch(branch),
      .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
      .reg_write(reg_write), .alu_op(alu_op), .reg_dst(reg_dst),
      .li_pending(li_pending)
`ifdef CTRL_PERF_CNT_EN
      , .dec_count(dec_count)
`endif
   );

   // Reference decode of a non-prefix word taken in normal state.
   function automatic logic [10:0] exp_op(input logic [6:0] w, input logic [1:0] rd);
      logic [2:0] o;
      logic br, mw, m2r, rw;
      o   = w[6:4];
      br  = (o == 3'd1);
      mw  = (o == 3'd2);
      m2r = (o == 3'd3);
      rw  = !(br || mw);
      return {1'b1, br, m2r, mw, 1'b0, rw, o, rd};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; instr_valid = 1'b0; instr = '0;
      repeat (2) @(posedge clk);
      #1;
      m_rd = 2'b00;
      checks++;
      if (obs !== {1'b0, 5'b0, 3'b111, 2'b00})
         $display("FAIL reset_bundle got=%b want=%b", obs, {1'b0, 5'b0, 3'b111, 2'b00});
      else passed++;
      checks++;
      if ({instr_ready, li_pending} !== 2'b10)
         $display("FAIL reset_ready_li got=%b want=10", {instr_ready, li_pending});
      else passed++;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Back-to-back stream of every non-lbu opcode, then an idle cycle.
   task automatic test_alu_ops();
      logic [6:0] words[7];
      words = '{7'b1000101, 7'b0001001, 7'b0010011, 7'b0100000,
                7'b1011110, 7'b1100001, 7'b1111111};
      for (int i = 0; i < 7; i++) begin
         instr = words[i]; instr_valid = 1'b1;
         sb_q.push_back(exp_op(words[i], m_rd));
         @(posedge clk); #1;
         checks++;
         if (sb_q.size() == 0)
            $display("FAIL alu_op%0d scoreboard empty got=%b", i, obs);
         else begin
            exp_b = sb_q.pop_front();
            if (obs !== exp_b) $display("FAIL alu_op%0d got=%b want=%b", i, obs, exp_b);
            else passed++;
         end
      end
      instr_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (obs !== {1'b0, 5'b0, 3'b111, m_rd})
         $display("FAIL idle_defaults got=%b want=%b", obs, {1'b0, 5'b0, 3'b111, m_rd});
      else passed++;
   endtask

   task automatic test_li();
      instr = 7'b0000010; instr_valid = 1'b1;
      m_rd = 2'b10;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checks++;
      if ({li_pending, dec_valid} !== 2'b10)
         $display("FAIL li_prefix got=%b want=10", {li_pending, dec_valid});
      else passed++;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({li_pending, dec_valid, reg_dst} !== {2'b10, m_rd})
         $display("FAIL li_hold got=%b want=%b", {li_pending, dec_valid, reg_dst}, {2'b10, m_rd});
      else passed++;
      instr = 7'b0101010; instr_valid = 1'b1;
      sb_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'b10});
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checks++;
      if (sb_q.size() == 0)
         $display("FAIL li_bundle scoreboard empty got=%b", obs);
      else begin
         exp_b = sb_q.pop_front();
         if (obs !== exp_b) $display("FAIL li_bundle got=%b want=%b", obs, exp_b);
         else passed++;
      end
      checks++;
      if (li_pending !== 1'b0) $display("FAIL li_done got=%b want=0", li_pending);
      else passed++;
   endtask

   task automatic test_lbu_stall();
      int unsigned stall;
      instr = 7'b0110100; instr_valid = 1'b1;
      sb_q.push_back(exp_op(7'b0110100, m_rd));
      @(posedge clk); #1;
      checks++;
      if (sb_q.size() == 0)
         $display("FAIL lbu_bundle scoreboard empty got=%b", obs);
      else begin
         exp_b = sb_q.pop_front();
         if (obs !== exp_b) $display("FAIL lbu_bundle got=%b want=%b", obs, exp_b);
         else passed++;
      end
      // Offer a word through the stall; it must wait.
      instr = 7'b1000101;
      stall = 0;
      while (instr_ready === 1'b0 && stall < 10) begin
         stall++;
         @(posedge clk); #1;
         checks++;
         if (dec_valid !== 1'b0) $display("FAIL stall_no_consume got=%b want=0", dec_valid);
         else passed++;
      end
      checks++;
      if (stall != 2) $display("FAIL stall_len got=%0d want=2", stall);
      else passed++;
      sb_q.push_back(exp_op(7'b1000101, m_rd));
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checks++;
      if (sb_q.size() == 0)
         $display("FAIL after_stall scoreboard empty got=%b", obs);
      else begin
         exp_b = sb_q.pop_front();
         if (obs !== exp_b) $display("FAIL after_stall got=%b want=%b", obs, exp_b);
         else passed++;
      end
      @(posedge clk); #1;
      checks++;
      if (dec_valid !== 1'b0) $display("FAIL after_stall_once got=%b want=0", dec_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_seq();
      instr = 7'b0000011; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (li_pending !== 1'b1) $display("FAIL mid_li_pending got=%b want=1", li_pending);
      else passed++;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_rd = 2'b00;
      checks++;
      if (li_pending !== 1'b0) $display("FAIL mid_li_reset got=%b want=0", li_pending);
      else passed++;
      instr = 7'b0100000; instr_valid = 1'b1;
      sb_q.push_back(exp_op(7'b0100000, m_rd));
      @(posedge clk); #1;
      instr_valid = 1'b0;
      checks++;
      if (sb_q.size() == 0)
         $display("FAIL post_reset_sb scoreboard empty got=%b", obs);
      else begin
         exp_b = sb_q.pop_front();
         if (obs !== exp_b) $display("FAIL post_reset_sb got=%b want=%b", obs, exp_b);
         else passed++;
      end
      // Reset in the middle of an lbu stall.
      instr = 7'b0110111; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_rd = 2'b00;
      checks++;
      if ({instr_ready, dec_valid} !== 2'b10)
         $display("FAIL mid_stall_reset got=%b want=10", {instr_ready, dec_valid});
      else passed++;
      @(posedge clk); #1;
   endtask

`ifdef CTRL_PERF_CNT_EN
   task automatic test_perf_count();
      int unsigned m_cnt;
      logic [6:0] w;
      reset_n = 1'b0; instr_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_cnt = 0;
      checks++;
      if (dec_count !== 4'd0) $display("FAIL cnt_reset got=%0d want=0", dec_count);
      else passed++;
      for (int i = 0; i < 16; i++) begin
         w = (i % 2 == 0) ? 7'b1000101 : 7'b0100000;
         instr = w; instr_valid = 1'b1;
         m_cnt++;
         @(posedge clk); #1;
      end
      instr = 7'b0000001;
      @(posedge clk); #1;
      instr = 7'b0111111;
      m_cnt++;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (dec_count !== 4'(m_cnt))
         $display("FAIL cnt_wrap got=%0d want=%0d", dec_count, 4'(m_cnt));
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_alu_ops();
      test_li();
      test_lbu_stall();
      test_reset_mid_seq();
`ifdef CTRL_PERF_CNT_EN
      test_perf_count();
`endif
      checks++;
      if (sb_q.size() != 0) $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
